// File: rtl/max_pkg.sv
// Shared definitions for the max-frame reducer and related QoR monitors.
package max_pkg;

    localparam int unsigned W_DEF  = 5;
    localparam int unsigned CW_DEF = 16;

    // Max stage pin map: operand A on pi00..pi04, B on pi05..pi09, result on po0..po4, all MSB first.
    localparam int unsigned PI_A_BASE = 0;
    localparam int unsigned PI_B_BASE = 5;
    localparam int unsigned PO_BASE   = 0;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_e;

    function automatic int unsigned msb_first_pin(input int unsigned base,
                                                  input int unsigned bitpos,
                                                  input int unsigned width);
        return base + (width - 1 - bitpos);
    endfunction

endpackage

// File: rtl/max_frame_reducer_if.sv
// Sample stream, frame result and external max-stage signals of the reducer.
interface max_frame_reducer_if #(
    parameter int unsigned W = 5
);
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_last;

    logic [W-1:0] cmp_a;
    logic [W-1:0] cmp_b;
    logic [W-1:0] cmp_max;

    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_max;
    logic [W-1:0] m_exact;
    logic         m_err;

    modport slave (
        input  s_valid, s_data, s_last, cmp_max, m_ready,
        output s_ready, cmp_a, cmp_b, m_valid, m_max, m_exact, m_err
    );

    modport master (
        output s_valid, s_data, s_last, cmp_max, m_ready,
        input  s_ready, cmp_a, cmp_b, m_valid, m_max, m_exact, m_err
    );
endinterface

// File: rtl/max_exact_ref.sv
// Exact unsigned W-bit maximum, the golden reference for approximate max stages.
module max_exact_ref #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);
    assign y_o = (b_i > a_i) ? b_i : a_i;
endmodule

// File: rtl/max_frame_reducer.sv
// Reduces each sample frame to one maximum through the external approximate
// max stage while tracking the exact maximum and counting mismatched frames.
module max_frame_reducer
    import max_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic                clk,
    input  logic                rst,
    max_frame_reducer_if.slave  bus,
    input  logic                clr_stats,
    output logic [CW-1:0]       err_count
);

    state_e        state_q, state_d;
    logic [W-1:0]  acc_apx_q, acc_apx_d;
    logic [W-1:0]  acc_ex_q, acc_ex_d;
    logic          m_valid_q, m_valid_d;
    logic [W-1:0]  m_max_q, m_max_d;
    logic [W-1:0]  m_exact_q, m_exact_d;
    logic          m_err_q, m_err_d;
    logic [CW-1:0] err_count_q, err_count_d;

    logic [W-1:0]  ex_max;
    logic          s_ready_c;
    logic [W-1:0]  cmp_a_c;
    logic [W-1:0]  cmp_b_c;
    logic          in_xfer;
    logic          load;

    max_exact_ref #(.W(W)) u_exact (
        .a_i (acc_ex_q),
        .b_i (bus.s_data),
        .y_o (ex_max)
    );

    always_comb begin
        state_d     = state_q;
        acc_apx_d   = acc_apx_q;
        acc_ex_d    = acc_ex_q;
        m_valid_d   = m_valid_q;
        m_max_d     = m_max_q;
        m_exact_d   = m_exact_q;
        m_err_d     = m_err_q;
        err_count_d = err_count_q;
        s_ready_c   = 1'b0;
        cmp_a_c     = '0;
        cmp_b_c     = '0;
        load        = 1'b0;
        in_xfer     = bus.s_valid && !rst;

        case (state_q)
            IDLE: begin
                s_ready_c = 1'b1;
                if (in_xfer) begin
                    acc_apx_d = bus.s_data;
                    acc_ex_d  = bus.s_data;
                    state_d   = bus.s_last ? HOLD : ACCUM;
                    load      = bus.s_last;
                end
            end
            ACCUM: begin
                s_ready_c = 1'b1;
                cmp_a_c   = acc_apx_q;
                cmp_b_c   = bus.s_data;
                if (in_xfer) begin
                    acc_apx_d = bus.cmp_max;
                    acc_ex_d  = ex_max;
                    if (bus.s_last) begin
                        state_d = HOLD;
                        load    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs load from the next-state accumulators so the result appears one cycle after the last sample.
        if (load) begin
            m_valid_d = 1'b1;
            m_max_d   = acc_apx_d;
            m_exact_d = acc_ex_d;
            m_err_d   = (acc_apx_d != acc_ex_d);
            if (m_err_d && (err_count_q != '1)) begin
                err_count_d = err_count_q + CW'(1);
            end
        end

        if (clr_stats) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_apx_q   <= '0;
            acc_ex_q    <= '0;
            m_valid_q   <= 1'b0;
            m_max_q     <= '0;
            m_exact_q   <= '0;
            m_err_q     <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_apx_q   <= acc_apx_d;
            acc_ex_q    <= acc_ex_d;
            m_valid_q   <= m_valid_d;
            m_max_q     <= m_max_d;
            m_exact_q   <= m_exact_d;
            m_err_q     <= m_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.s_ready = s_ready_c && !rst;
    assign bus.cmp_a   = cmp_a_c;
    assign bus.cmp_b   = cmp_b_c;
    assign bus.m_valid = m_valid_q;
    assign bus.m_max   = m_max_q;
    assign bus.m_exact = m_exact_q;
    assign bus.m_err   = m_err_q;
    assign err_count   = err_count_q;

endmodule

// File: doc/max_frame_reducer.md
Name: max_frame_reducer

Overview:
- Streaming wrapper around the partitioned 5-bit approximate max stage (10 operand pins, 5 result pins).
- Accepts a stream of unsigned samples and reduces each frame to one maximum by iterating the external compare stage.
- In parallel, tracks the exact maximum and counts frames where the approximate result differs, giving an on-line QoR monitor for the approximated netlist.

Parameters:
- W, 5, sample/result width; must equal the max stage operand width.
- CW, 16, width of the saturating mismatch counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample ready.
- s_data  in  W  unsigned sample.
- s_last  in  1  marks the final sample of a frame.
- cmp_a  out  W  operand A to max stage (pi00..pi04, MSB first).
- cmp_b  out  W  operand B to max stage (pi05..pi09, MSB first).
- cmp_max  in  W  max stage result (po0..po4, MSB first); combinational, valid in the same cycle.
- m_valid  out  1  frame result valid.
- m_ready  in  1  frame result ready.
- m_max  out  W  approximate frame maximum.
- m_exact  out  W  exact frame maximum.
- m_err  out  1  1 when m_max != m_exact for the presented frame.
- clr_stats  in  1  synchronous clear of err_count.
- err_count  out  CW  saturating count of mismatched frames.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; acc_apx=0, acc_ex=0.
  - m_valid=0, m_max=0, m_exact=0, m_err=0, err_count=0.
  - s_ready is forced 0 while rst is high.
- Handshakes:
  - Input transfer on s_valid & s_ready; output transfer on m_valid & m_ready.
  - Once m_valid is raised, m_max, m_exact and m_err hold stable until the transfer.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - s_ready=1.
  - On transfer: acc_apx<=s_data and acc_ex<=s_data; no compare is used for the first sample.
  - If s_last: go to HOLD, otherwise go to ACCUM.
- ACCUM:
  - s_ready=1; cmp_a=acc_apx and cmp_b=s_data (combinational).
  - On transfer: acc_apx<=cmp_max; acc_ex<=(s_data>acc_ex ? s_data : acc_ex).
  - If s_last: go to HOLD and load the output registers from the next-state accumulator values, so m_valid=1 one cycle after the last input transfer.
  - Without a transfer: no state change.
- Output loading on entry to HOLD:
  - m_max and m_exact take the final accumulator values.
  - m_err=(final approx != final exact).
  - err_count increments on m_err, saturating at 2^CW-1.
- HOLD:
  - s_ready=0.
  - On the output transfer: m_valid<=0 and state<=IDLE.
  - Throughput is one idle cycle per frame; back-to-back acceptance after m_ready is not required.
- cmp_a and cmp_b outside ACCUM are 0. cmp_max is ignored outside ACCUM transfers.
- Single-sample frame (s_last on the first sample): result is the sample itself, m_err=0, max stage unused.
- clr_stats=1: err_count<=0 next cycle. If it coincides with an increment, the clear wins. m_err is unaffected.
- rst mid-frame or in HOLD: the partial or pending frame is discarded with no output and err_count is zeroed.
- Width rules: all compares unsigned. Accumulators are W bits with no widening.

Decomposition:
- Shared package max_pkg holds:
  - W default (5) and CW default (16).
  - state enum {IDLE, ACCUM, HOLD}.
  - MSB-first pin-mapping constants for the max stage.
- One sub-module, max_exact_ref: combinational exact W-bit unsigned max, used for acc_ex and reusable by other QoR monitors.
- The approximate max stage is instantiated outside this block, so the BLASYS flow can swap netlists freely.

Test Plan:
- Exact stage tied in (cmp_max = exact max); frame 3,17,9,31,4 with last on 4 -> m_valid one cycle after the last transfer; m_max=31, m_exact=31, m_err=0, err_count=0.
- Stage model forced to return cmp_b when cmp_a=20 and cmp_b=5; frame 20,5 -> m_max=5, m_exact=20, m_err=1, err_count=1.
- Single-sample frame 0x1A with s_last -> m_max=m_exact=0x1A, m_err=0, cmp_a and cmp_b stay 0 throughout.
- m_ready held 0 for 10 cycles after m_valid -> outputs stable, s_ready=0, extra s_valid pulses not accepted; m_ready=1 -> IDLE next cycle and s_ready=1.
- CW=2 with four mismatched frames -> err_count 1,2,3,3 (saturates); then clr_stats coinciding with a fifth mismatch -> err_count=0.
- rst asserted mid-frame after 7,12 -> no m_valid, all outputs zero; new frame 2,1 -> m_max=2.
